// File: rtl/flush_arbiter.sv
// flush_arbiter: oldest-first exception/branch flush arbiter with post-flush shadow filter; branch path and shadow enabled by FLUSH_ARB_BRANCH_EN
module flush_arbiter #(
  parameter int ROB_ID_W      = 7,
  parameter int NUM_BR        = 2,
  parameter int SHADOW_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exc_valid,
  input  logic [ROB_ID_W-1:0]        exc_rob_id,
  input  logic [31:0]                exc_target,
  input  logic [NUM_BR-1:0]          br_valid,
  input  logic [NUM_BR*ROB_ID_W-1:0] br_rob_id,
  input  logic [NUM_BR*32-1:0]       br_target,
  output logic                       flush,
  output logic                       flush_is_exception,
  output logic [ROB_ID_W-1:0]        flush_rob_id,
  output logic [31:0]                flush_target,
  output logic                       busy
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SHADOW} state_e;
  state_e state_q, state_d;
  logic exc_q, exc_d;
  logic [ROB_ID_W-1:0] id_q, id_d;
  logic [31:0] tgt_q, tgt_d;
  logic br_hit;
  logic [ROB_ID_W-1:0] br_id;
  logic [31:0] br_tgt;
`ifdef FLUSH_ARB_BRANCH_EN
  localparam int CNT_W = SHADOW_CYCLES > 0 ? $clog2(SHADOW_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  function automatic logic older(input logic [ROB_ID_W-1:0] a, input logic [ROB_ID_W-1:0] b);
    return a[ROB_ID_W-1] ^ b[ROB_ID_W-1] ^ (a[ROB_ID_W-2:0] < b[ROB_ID_W-2:0]);
  endfunction
  // pick the oldest eligible branch; strict compare keeps the lowest index on equal ids
  always_comb begin
    br_hit = 1'b0;
    br_id  = '0;
    br_tgt = '0;
    for (int i = 0; i < NUM_BR; i++)
      if (br_valid[i] && (state_q == S_IDLE || older(br_rob_id[i*ROB_ID_W +: ROB_ID_W], id_q)) &&
          (!br_hit || older(br_rob_id[i*ROB_ID_W +: ROB_ID_W], br_id))) begin
        br_hit = 1'b1;
        br_id  = br_rob_id[i*ROB_ID_W +: ROB_ID_W];
        br_tgt = br_target[i*32 +: 32];
      end
  end
  // shadow window countdown
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  logic unused_br;
  assign unused_br = ^{br_valid, br_rob_id, br_target} ^ (SHADOW_CYCLES != 0);
  assign br_hit = 1'b0;
  assign br_id  = '0;
  assign br_tgt = '0;
`endif
  // accept the winning request (exception first), else walk FLUSH -> SHADOW -> IDLE
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    id_d    = id_q;
    tgt_d   = tgt_q;
`ifdef FLUSH_ARB_BRANCH_EN
    cnt_d   = cnt_q;
`endif
    if (exc_valid || br_hit) begin
      state_d = S_FLUSH;
      exc_d   = exc_valid;
      id_d    = exc_valid ? exc_rob_id : br_id;
      tgt_d   = exc_valid ? exc_target : br_tgt;
    end else if (state_q == S_FLUSH) begin
`ifdef FLUSH_ARB_BRANCH_EN
      state_d = SHADOW_CYCLES == 0 ? S_IDLE : S_SHADOW;
      cnt_d   = CNT_W'(SHADOW_CYCLES);
`else
      state_d = S_IDLE;
`endif
    end
`ifdef FLUSH_ARB_BRANCH_EN
    else if (state_q == S_SHADOW) begin
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? S_IDLE : S_SHADOW;
    end
`endif
  end
  // state and latched flush contents
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      exc_q   <= 1'b0;
      id_q    <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      id_q    <= id_d;
      tgt_q   <= tgt_d;
    end
  end
  assign flush              = state_q == S_FLUSH;
  assign busy               = state_q != S_IDLE;
  assign flush_is_exception = exc_q;
  assign flush_rob_id       = id_q;
  assign flush_target       = tgt_q;
endmodule

// File: tb/tb_flush_arbiter.sv
// tb_flush_arbiter: directed vector table plus randomized run against a reference model
module tb_flush_arbiter;
  localparam int W  = 7;
  localparam int NB = 2;
  localparam int SH = 2;
`ifdef FLUSH_ARB_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, exc_valid;
  logic [W-1:0] exc_rob_id;
  logic [31:0] exc_target;
  logic [NB-1:0] br_valid;
  logic [NB*W-1:0] br_rob_id;
  logic [NB*32-1:0] br_target;
  logic flush, flush_is_exception, busy;
  logic [W-1:0] flush_rob_id;
  logic [31:0] flush_target;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  flush_arbiter #(.ROB_ID_W(W), .NUM_BR(NB), .SHADOW_CYCLES(SH)) dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_rob_id(exc_rob_id),
    .exc_target(exc_target), .br_valid(br_valid), .br_rob_id(br_rob_id),
    .br_target(br_target), .flush(flush), .flush_is_exception(flush_is_exception),
    .flush_rob_id(flush_rob_id), .flush_target(flush_target), .busy(busy)
  );
  typedef struct {
    logic rst, ev;
    logic [W-1:0] eid;
    logic [31:0] et;
    logic [1:0] bv;
    logic [W-1:0] b0, b1;
    logic [31:0] t0, t1;
    logic xf, xe;
    logic [W-1:0] xi;
    logic [31:0] xt;
    logic xb;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic rst, ev, input logic [W-1:0] eid, input logic [31:0] et,
                     input logic [1:0] bv, input logic [W-1:0] b0, b1, input logic [31:0] t0, t1,
                     input logic xf, xe, input logic [W-1:0] xi, input logic [31:0] xt, input logic xb);
    vec_t v;
    v.rst = rst; v.ev = ev; v.eid = eid; v.et = et; v.bv = bv; v.b0 = b0; v.b1 = b1;
    v.t0 = t0; v.t1 = t1; v.xf = xf; v.xe = xe; v.xi = xi; v.xt = xt; v.xb = xb;
    tbl.push_back(v);
  endtask
  task automatic check(input string name, input logic ef, ee, input logic [W-1:0] ei,
                       input logic [31:0] et, input logic eb);
    checks++;
    if ({flush, flush_is_exception, flush_rob_id, flush_target, busy} !== {ef, ee, ei, et, eb}) begin
      errors++;
      $display("FAIL %s: got flush=%0b exc=%0b id=%h tgt=%h busy=%0b, want flush=%0b exc=%0b id=%h tgt=%h busy=%0b",
               name, flush, flush_is_exception, flush_rob_id, flush_target, busy, ef, ee, ei, et, eb);
    end
  endtask
  // reference model: expected registered outputs plus number of shadow cycles still owed
  logic m_flush, m_exc, m_busy;
  logic [W-1:0] m_id;
  logic [31:0] m_tgt;
  int m_tail;
  function automatic bit m_older(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = b - a;
    return d != 0 && int'(d) < (1 << (W - 1));
  endfunction
  task automatic model_step();
    int pick;
    logic [W-1:0] id;
    pick = -1;
    if (reset) begin
      m_flush = 0; m_exc = 0; m_id = 0; m_tgt = 0; m_busy = 0; m_tail = 0;
      return;
    end
    if (BR_EN)
      for (int i = 0; i < NB; i++) begin
        id = br_rob_id[i*W +: W];
        if (br_valid[i] && (!m_busy || m_older(id, m_id)) && (pick < 0 || m_older(id, br_rob_id[pick*W +: W])))
          pick = i;
      end
    if (exc_valid) begin
      m_flush = 1; m_exc = 1; m_id = exc_rob_id; m_tgt = exc_target; m_busy = 1; m_tail = BR_EN ? SH : 0;
    end else if (pick >= 0) begin
      m_flush = 1; m_exc = 0; m_id = br_rob_id[pick*W +: W]; m_tgt = br_target[pick*32 +: 32];
      m_busy = 1; m_tail = SH;
    end else begin
      m_flush = 0;
      m_busy = m_tail > 0;
      if (m_tail > 0) m_tail--;
    end
  endtask
  initial begin
    logic [W-1:0] base;
    reset = 1; exc_valid = 0; exc_rob_id = 0; exc_target = 0; br_valid = 0; br_rob_id = 0; br_target = 0;
    for (int i = 0; i < 3; i++) add(1, 1, 7'h20, 32'hA, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 7'h20, 32'hA, 2'b00, 0, 0, 0, 0, 1, 1, 7'h20, 32'hA, 1);
`ifdef FLUSH_ARB_BRANCH_EN
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 7'h20, 32'hA, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 7'h20, 32'hA, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 7'h20, 32'hA, 0);
    add(0, 0, 0, 0, 2'b11, 7'h05, 7'h03, 32'h1000, 32'h2000, 1, 0, 7'h03, 32'h2000, 1);
    add(0, 0, 0, 0, 2'b11, 7'h7E, 7'h01, 32'h3000, 32'h4000, 1, 0, 7'h7E, 32'h3000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h7E, 32'h3000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h7E, 32'h3000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h7E, 32'h3000, 0);
    add(0, 0, 0, 0, 2'b11, 7'h10, 7'h10, 32'h5000, 32'h6000, 1, 0, 7'h10, 32'h5000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h10, 32'h5000, 1);
    add(0, 0, 0, 0, 2'b01, 7'h12, 0, 32'h9000, 0, 0, 0, 7'h10, 32'h5000, 1);
    add(0, 0, 0, 0, 2'b10, 0, 7'h0C, 0, 32'h7000, 1, 0, 7'h0C, 32'h7000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h0C, 32'h7000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h0C, 32'h7000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'h0C, 32'h7000, 0);
    add(0, 1, 7'h20, 32'hA, 2'b01, 7'h1F, 0, 32'hB000, 0, 1, 1, 7'h20, 32'hA, 1);
`else
    add(0, 0, 0, 0, 2'b11, 7'h05, 7'h03, 32'h1000, 32'h2000, 0, 1, 7'h20, 32'hA, 0);
    add(0, 0, 0, 0, 2'b01, 7'h10, 0, 32'h3000, 0, 0, 1, 7'h20, 32'hA, 0);
    add(0, 1, 7'h21, 32'hB, 2'b11, 7'h03, 7'h05, 32'h1000, 32'h2000, 1, 1, 7'h21, 32'hB, 1);
    add(0, 1, 7'h22, 32'hC, 2'b00, 0, 0, 0, 0, 1, 1, 7'h22, 32'hC, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 7'h22, 32'hC, 0);
    add(0, 1, 7'h30, 32'hD, 2'b00, 0, 0, 0, 0, 1, 1, 7'h30, 32'hD, 1);
    add(0, 0, 0, 0, 2'b10, 0, 7'h01, 0, 32'h4000, 0, 1, 7'h30, 32'hD, 0);
    add(0, 1, 7'h40, 32'hE, 2'b00, 0, 0, 0, 0, 1, 1, 7'h40, 32'hE, 1);
`endif
    add(1, 1, 7'h41, 32'hF, 2'b11, 7'h01, 7'h02, 32'h1, 32'h2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[k]) begin
      reset = tbl[k].rst; exc_valid = tbl[k].ev; exc_rob_id = tbl[k].eid; exc_target = tbl[k].et;
      br_valid = tbl[k].bv; br_rob_id = {tbl[k].b1, tbl[k].b0}; br_target = {tbl[k].t1, tbl[k].t0};
      @(posedge clk);
      #1 check($sformatf("vec%0d", k), tbl[k].xf, tbl[k].xe, tbl[k].xi, tbl[k].xt, tbl[k].xb);
    end
    base = 7'($urandom);
    for (int n = 0; n < 400; n++) begin
      base = base + W'($urandom_range(0, 1));
      reset = n == 0 || $urandom_range(0, 49) == 0;
      exc_valid = $urandom_range(0, 5) == 0;
      exc_rob_id = base + W'($urandom_range(0, 40));
      exc_target = $urandom;
      for (int i = 0; i < NB; i++) begin
        br_valid[i] = $urandom_range(0, 2) == 0;
        br_rob_id[i*W +: W] = base + W'($urandom_range(0, 40));
        br_target[i*32 +: 32] = $urandom;
      end
      model_step();
      @(posedge clk);
      #1 check($sformatf("rand%0d", n), m_flush, m_exc, m_id, m_tgt, m_busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flush_arbiter.md
# flush_arbiter

Parametrised successor to the single-source flush path. Collects a commit-time exception request from the ROB and up to NUM_BR branch-misprediction requests from the branch execution units. Selects the oldest request by ROB age and drives a registered one-cycle pipeline flush with redirect target. After each flush it holds a shadow window that drops stale requests from instructions the flush has already killed.

## Interface

Parameters:
- ROB_ID_W, 7, ROB id width; MSB is the wrap bit, low ROB_ID_W-1 bits index the ROB.
- NUM_BR, 2, number of branch-failure request channels (≥1).
- SHADOW_CYCLES, 2, cycles after the flush pulse during which younger/equal branch requests are dropped (≥0).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- exc_valid  in  1  ROB commit-time exception/ertn request.
- exc_rob_id  in  ROB_ID_W  ROB id of the excepting instruction.
- exc_target  in  32  redirect PC (exception entry or era).
- br_valid  in  NUM_BR  per-channel branch-failure request.
- br_rob_id  in  NUM_BR×ROB_ID_W  packed, channel i at [i*ROB_ID_W +: ROB_ID_W].
- br_target  in  NUM_BR×32  packed correct-path PCs.
- flush  out  1  one-cycle flush pulse.
- flush_is_exception  out  1  pulse caused by exception (0 = branch failure).
- flush_rob_id  out  ROB_ID_W  ROB id of the flushing instruction; younger entries are squashed.
- flush_target  out  32  redirect PC.
- busy  out  1  high in FLUSH or SHADOW.

## Operation

- Age rule: older(a,b) = a[MSB] ^ b[MSB] ^ (a[MSB-1:0] < b[MSB-1:0]). Equal ids are not older.
- Branch selection: the oldest valid channel wins. On equal rob_id, the lowest index wins.
- Exception priority: exc_valid beats every branch request in the same cycle, regardless of ids. A commit-time instruction is the ROB head.
- Filter: in FLUSH or SHADOW, a branch request is eligible only if older(br_rob_id, held_rob_id). Exceptions are always eligible.
- FSM states:
  - IDLE: any eligible request → FLUSH, latching id, target and is_exception.
  - FLUSH: outputs pulse for exactly one cycle. Next state:
    - FLUSH again if an eligible request is present, with re-latch.
    - otherwise SHADOW with counter = SHADOW_CYCLES.
    - otherwise IDLE if SHADOW_CYCLES = 0.
  - SHADOW: each cycle, an eligible request → FLUSH. Otherwise the counter decrements; at 1 → IDLE.
- held_rob_id keeps the last flushing id until the next accepted request.
- Reset values:
  - flush=0, flush_is_exception=0, flush_rob_id=0, flush_target=0, busy=0.
  - state=IDLE, counter=0.
- Reset mid-operation: aborts any pulse or shadow on the next edge. No flush is emitted in the reset cycle.

## Timing

- Latency: request sampled at edge N → flush high for cycle N+1 (all outputs registered).
- Back-to-back: an eligible request during the FLUSH cycle gives a second pulse on the following cycle. flush may stay high in consecutive cycles only with distinct latched contents.
- No handshake. Requesters hold nothing; a dropped request is discarded, not queued.
- busy is high from cycle N+1 through the last SHADOW cycle.

## Configuration

- FLUSH_ARB_BRANCH_EN defined: full behaviour above.
- FLUSH_ARB_BRANCH_EN undefined:
  - br_* inputs are ignored; only exceptions cause flushes.
  - flush_is_exception is always 1 on a pulse.
  - SHADOW is skipped: FLUSH → IDLE. busy is high only during FLUSH.

## Test plan

- Reset held 3 cycles with exc_valid=1 → flush=0 throughout; first pulse appears one cycle after reset falls.
- br_valid=2'b11, ids 7'h05/7'h03, targets 0x1000/0x2000 → next cycle flush=1, flush_rob_id=7'h03, flush_target=0x2000, flush_is_exception=0.
- Wrap case: ids 7'h7E and 7'h01 → 7'h7E selected. Equal ids 7'h10 on both channels → channel 0 target chosen.
- exc_valid with id 7'h20 alongside br_valid with id 7'h1F in the same cycle → exception flush, rob_id 7'h20, is_exception=1.
- Flush on id 7'h10, SHADOW_CYCLES=2:
  - branch id 7'h12 in SHADOW → dropped, no pulse.
  - branch id 7'h0C in SHADOW → second pulse with 7'h0C.
  - busy falls after 2 idle shadow cycles.
- Build without FLUSH_ARB_BRANCH_EN, br_valid=1 → no flush. exc_valid=1 → pulse one cycle later and busy high for exactly one cycle.
